vx_cmt_instret_ctrl: RTL and testbench

VX_CMT_INSTRET_CTRL -- requirements
Module: VX_cmt_instret_ctrl

---
 rtl/vx_cmt_instret_ctrl.sv | 66 ++++++
 tb/tb_vx_cmt_instret_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vx_cmt_instret_ctrl.sv
// rtl/vx_cmt_instret_ctrl.sv - commit-size aggregator and 64-bit instret counter; FPU unit enabled by CMT_FPU_EN
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

module vx_cmt_instret_ctrl #(
    parameter int unsigned NUM_THREADS = `NUM_THREADS,
`ifdef CMT_FPU_EN
    localparam int unsigned NU = 6,
`else
    localparam int unsigned NU = 5,
`endif
    localparam int unsigned CW = $clog2(NU * NUM_THREADS + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NU-1:0]               unit_valid,
    input  logic [NU*NUM_THREADS-1:0]   unit_tmask,
    output logic [NU-1:0]               unit_ready,
    input  logic                        csr_wr_valid,
    input  logic                        csr_wr_hi,
    input  logic [31:0]                 csr_wr_data,
    input  logic                        inhibit,
    output logic                        cmt_valid,
    output logic [CW-1:0]               cmt_commit_size,
    output logic [63:0]                 instret
);

    logic [NU-1:0] fired;
    logic [CW-1:0] sum;
    logic          any_fired;

    // A software write to instret owns the counter for that cycle, so all commits stall.
    assign unit_ready = {NU{~csr_wr_valid}};
    assign fired      = unit_valid & unit_ready;
    assign any_fired  = |fired;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NU; i++) begin
            for (int j = 0; j < NUM_THREADS; j++) begin
                sum = sum + CW'(fired[i] & unit_tmask[i*NUM_THREADS + j]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmt_valid       <= 1'b0;
            cmt_commit_size <= '0;
            instret         <= '0;
        end else begin
            cmt_valid       <= any_fired;
            cmt_commit_size <= any_fired ? sum : '0;
            if (csr_wr_valid) begin
                if (csr_wr_hi)
                    instret[63:32] <= csr_wr_data;
                else
                    instret[31:0]  <= csr_wr_data;
            end else if (any_fired && !inhibit) begin
                instret <= instret + 64'(sum);
            end
        end
    end

endmodule

// File: tb/tb_vx_cmt_instret_ctrl.sv
// tb/tb_vx_cmt_instret_ctrl.sv - directed and random checks of vx_cmt_instret_ctrl against a reference model
module tb_vx_cmt_instret_ctrl;

    localparam int NT  = 4;
`ifdef CMT_FPU_EN
    localparam int NU  = 6;
`else
    localparam int NU  = 5;
`endif
    localparam int TMW = NU * NT;
    localparam int CW  = $clog2(NU * NT + 1);

    logic            clk = 1'b0;
    logic            reset;
    logic [NU-1:0]   unit_valid;
    logic [TMW-1:0]  unit_tmask;
    logic [NU-1:0]   unit_ready;
    logic            csr_wr_valid;
    logic            csr_wr_hi;
    logic [31:0]     csr_wr_data;
    logic            inhibit;
    logic            cmt_valid;
    logic [CW-1:0]   cmt_commit_size;
    logic [63:0]     instret;

    int n_checks = 0;
    int n_fails  = 0;

    longint unsigned m_instret = 0;
    bit              m_valid   = 0;
    int unsigned     m_size    = 0;

    vx_cmt_instret_ctrl #(.NUM_THREADS(NT)) dut (
        .clk             (clk),
        .reset           (reset),
        .unit_valid      (unit_valid),
        .unit_tmask      (unit_tmask),
        .unit_ready      (unit_ready),
        .csr_wr_valid    (csr_wr_valid),
        .csr_wr_hi       (csr_wr_hi),
        .csr_wr_data     (csr_wr_data),
        .inhibit         (inhibit),
        .cmt_valid       (cmt_valid),
        .cmt_commit_size (cmt_commit_size),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check ready, advance model, check registered outputs.
    task automatic cycle(input logic [NU-1:0] v, input logic [TMW-1:0] tm,
                         input bit wr, input bit hi, input logic [31:0] data,
                         input bit inh, input bit rst, input string tag);
        int unsigned total;
        bit          accepted;
        logic [TMW-1:0] tmc;
        reset        = rst;
        unit_valid   = v;
        unit_tmask   = tm;
        csr_wr_valid = wr;
        csr_wr_hi    = hi;
        csr_wr_data  = data;
        inhibit      = inh;
        #1;
        check({tag, ".ready"}, 64'(unit_ready), wr ? 64'd0 : 64'((1 << NU) - 1));
        accepted = !wr && (v != '0);
        total = 0;
        tmc = tm;
        if (!wr)
            for (int u = 0; u < NU; u++)
                if (v[u]) total += $countones(tmc[u*NT +: NT]);
        if (rst) begin
            m_valid = 0; m_size = 0; m_instret = 0;
        end else begin
            m_valid = accepted;
            m_size  = accepted ? total : 0;
            if (wr) begin
                if (hi) m_instret = {data, m_instret[31:0]};
                else    m_instret = {m_instret[63:32], data};
            end else if (accepted && !inh) begin
                m_instret = m_instret + total;
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".valid"},   64'(cmt_valid),       64'(m_valid));
        check({tag, ".size"},    64'(cmt_commit_size), 64'(m_size));
        check({tag, ".instret"}, instret,              m_instret);
    endtask

    function automatic logic [TMW-1:0] all_f();
        logic [TMW-1:0] t;
        t = '1;
        return t;
    endfunction

    initial begin
        reset = 1; unit_valid = '0; unit_tmask = '0;
        csr_wr_valid = 0; csr_wr_hi = 0; csr_wr_data = '0; inhibit = 0;
        @(posedge clk); #1;

        cycle('0, '0, 0, 0, 32'h0, 0, 1, "reset");
        cycle('1, all_f(), 0, 0, 32'h0, 0, 0, "all_units");
`ifdef CMT_FPU_EN
        check("all_units.size24", 64'(cmt_commit_size), 64'd24);
`else
        check("all_units.size20", 64'(cmt_commit_size), 64'd20);
`endif
        cycle(NU'(2'b11), TMW'(8'b0000_0101), 0, 0, 32'h0, 0, 0, "alu_lsu");
        cycle('1, all_f(), 1, 1, 32'h1, 0, 0, "csr_hi");
        check("csr_hi.const", instret, 64'h1_0000_0000 | 64'(m_instret[31:0]));
        cycle(NU'(1), TMW'(4'hF), 0, 0, 32'h0, 1, 0, "inhibit");
        cycle('0, '0, 1, 0, 32'hFFFF_FFFE, 0, 0, "preset_lo");
        cycle('0, '0, 1, 1, 32'hFFFF_FFFF, 0, 0, "preset_hi");
        cycle(NU'(1), TMW'(4'b0111), 0, 0, 32'h0, 0, 0, "wrap");
        check("wrap.const", instret, 64'h1);
        cycle(NU'(1), TMW'(4'hF), 0, 0, 32'h0, 0, 1, "reset_commit");
        cycle(NU'(1), TMW'(4'hF), 0, 0, 32'h0, 0, 0, "post_reset");
        cycle('1, '0, 0, 0, 32'h0, 0, 0, "zero_mask");

        for (int k = 0; k < 300; k++) begin
            cycle(NU'($urandom), TMW'($urandom),
                  ($urandom_range(0, 7) == 0), 1'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
